// File: rtl/instr_cache_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
//   fill_state_t : refill FSM states (IDLE, FILL, DONE)
//   WORD_OFF_W   : word-offset width of the default line size
//   BYTE_OFF_W   : byte-offset width within a 32-bit word
package instr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int unsigned WORD_OFF_W    = 2;
    localparam int unsigned DEF_BLOCKSIZE = 1 << WORD_OFF_W;
    localparam int unsigned BYTE_OFF_W    = 2;

endpackage

// File: rtl/instr_cache_victim_sel.sv
// Round-robin victim pointer for the instruction cache.
//   clk, reset (sync, active-low)
//   advance : step to the next way at the end of a refill
//   victim  : one-hot selected way, way 0 after reset
module instr_cache_victim_sel #(
    parameter int unsigned ways = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    output logic [ways-1:0] victim
);

    localparam logic [ways-1:0] FIRST = ways'(1);
    localparam logic [ways-1:0] LAST  = FIRST << (ways - 1);

    // One-hot rotate; wraps from the last way back to way 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            victim <= FIRST;
        end else if (advance) begin
            victim <= (victim == LAST) ? FIRST : (victim << 1);
        end
    end

endmodule

// File: rtl/instr_cache_fill_ctrl.sv
// Instruction-cache miss handler and line refill controller.
// Detects a fetch miss, stalls fetch, bursts one line from memory and writes
// it beat-by-beat into the round-robin victim way, then releases the stall.
//   clk, reset (sync, active-low)
//   req, A, hit              : fetch-side lookup
//   stall, busy              : fetch stall / refill in progress
//   mem_req, mem_addr        : memory read request and current beat address
//   mem_ready, mem_rd        : beat accepted / beat data
//   way_we, way_wd, way_a    : one-hot write port into the victim way
// Build option: FILL_CRITICAL_WORD_FIRST_EN starts the burst at the missing
// word and wraps the offset modulo the line size.
module instr_cache_fill_ctrl
    import instr_cache_pkg::*;
#(
    parameter int unsigned blocksize = DEF_BLOCKSIZE,
    parameter int unsigned ways      = 2,
    parameter int unsigned tagbits   = 14
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [31:0]     A,
    input  logic            hit,
    output logic            stall,
    output logic            busy,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    input  logic            mem_ready,
    input  logic [31:0]     mem_rd,
    output logic [ways-1:0] way_we,
    output logic [31:0]     way_wd,
    output logic [31:0]     way_a
);

    localparam int unsigned OFFW  = $clog2(blocksize);
    localparam int unsigned LINEW = 32 - OFFW - BYTE_OFF_W;
    localparam logic [OFFW-1:0] LAST_BEAT = OFFW'(blocksize - 1);

    // Reject line sizes that are not a power of two >= 2 and empty tags.
    if (blocksize < 2 || (blocksize & (blocksize - 1)) != 0 || tagbits == 0 || ways == 0) begin : g_cfg_invalid
        $error("instr_cache_fill_ctrl: unsupported configuration");
    end

    fill_state_t      state;
    logic [LINEW-1:0] line_q;
    logic [OFFW-1:0]  start_q;
    logic [OFFW-1:0]  count_q;
    logic [ways-1:0]  victim_q;
    logic [ways-1:0]  rr_victim;
    logic [OFFW-1:0]  beat_off;
    logic [31:0]      cur_addr;
    logic             miss;
    logic             filling;
    logic             beat;
    logic             unused_a;

    assign unused_a = ^A[OFFW+BYTE_OFF_W-1:0];

    instr_cache_victim_sel #(
        .ways(ways)
    ) u_victim_sel (
        .clk    (clk),
        .reset  (reset),
        .advance(state == DONE),
        .victim (rr_victim)
    );

    assign miss     = req & ~hit;
    // Offset arithmetic is OFFW bits wide, so it wraps modulo the line size.
    assign beat_off = start_q + count_q;
    assign cur_addr = {line_q, beat_off, {BYTE_OFF_W{1'b0}}};

    // Outputs are gated by reset so a mid-fill reset stops writes at once.
    assign filling  = reset && (state == FILL);
    assign beat     = filling && mem_ready;
    assign stall    = reset && ((state == IDLE) ? miss : 1'b1);
    assign busy     = reset && (state != IDLE);
    assign mem_req  = filling;
    assign mem_addr = filling ? cur_addr : 32'd0;
    assign way_we   = beat ? victim_q : '0;
    assign way_wd   = beat ? mem_rd : 32'd0;
    assign way_a    = beat ? cur_addr : 32'd0;

    // Refill FSM: latch line and victim on a miss, count beats, one DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            line_q   <= '0;
            start_q  <= '0;
            count_q  <= '0;
            victim_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        line_q   <= A[31:OFFW+BYTE_OFF_W];
`ifdef FILL_CRITICAL_WORD_FIRST_EN
                        start_q  <= A[OFFW+BYTE_OFF_W-1:BYTE_OFF_W];
`else
                        start_q  <= '0;
`endif
                        victim_q <= rr_victim;
                        count_q  <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        count_q <= count_q + OFFW'(1);
                        if (count_q == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
